piso_serializer: RTL and testbench

Parallel-in, serial-out stage that sits directly upstream of the 4-bit left shift register and drives its serial `d` input. It accepts parallel words over a valid/ready handshake and buffers up to two of them. Each word is shifted out MSB-first, one bit per clock, so a downstream `{out[WIDTH-2:0], d}` register holds the original word exactly WIDTH cycles after the first bit. Back-to-back words stream with no idle gap.

---
 rtl/piso_serializer.sv | 133 +++++++++++++
 tb/tb_piso_serializer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out stage: 2-entry input FIFO feeding a WIDTH-bit
// MSB-first shifter. Back-to-back words stream with no idle gap.
module piso_serializer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             d,
  output logic             d_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] fifo_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             d_q, d_d;
  logic             d_valid_q, d_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             busy_q, busy_d;
  logic             push;
  logic             pop;

  assign din_ready   = !rst && (count_q != 2'd2);
  assign push        = din_valid && din_ready;

  assign d           = d_q;
  assign d_valid     = d_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

  // Pop decision uses the registered occupancy, so a word pushed at an
  // edge can never be loaded at that same edge.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != 2'd0) begin
          pop     = 1'b1;
          shift_d = fifo_q[rd_ptr_q];
          cnt_d   = CW'(WIDTH - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          if (count_q != 2'd0) begin
            pop     = 1'b1;
            shift_d = fifo_q[rd_ptr_q];
            cnt_d   = CW'(WIDTH - 1);
          end else begin
            shift_d = '0;
            state_d = IDLE;
          end
        end else begin
          shift_d = shift_q << 1;
          cnt_d   = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Serial outputs are registered from next-state so d lines up with the
  // shifter contents in the cycle after each edge.
  always_comb begin
    d_d           = (state_d == SHIFT) && shift_d[WIDTH-1];
    d_valid_d     = (state_d == SHIFT);
    frame_start_d = pop;
    busy_d        = (state_d == SHIFT) || (count_d != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= '0;
      shift_q       <= '0;
      cnt_q         <= '0;
      d_q           <= 1'b0;
      d_valid_q     <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      d_q           <= d_d;
      d_valid_q     <= d_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= din;
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: vector table for reset / single word /
// back-to-back, then hand-written backpressure, mid-word reset and WIDTH=8.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst, dv, rdy, d, dval, fs, busy;
  logic [3:0] din;
  logic       rst8, dv8, rdy8, d8, dval8, fs8, busy8;
  logic [7:0] din8;
  logic [3:0] ds = '0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .din(din), .din_valid(dv), .din_ready(rdy),
    .d(d), .d_valid(dval), .frame_start(fs), .busy(busy)
  );

  piso_serializer #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst8), .din(din8), .din_valid(dv8), .din_ready(rdy8),
    .d(d8), .d_valid(dval8), .frame_start(fs8), .busy(busy8)
  );

  // Downstream 4-bit left shift register fed by d.
  always @(posedge clk) ds <= {ds[2:0], d};

  typedef struct {
    logic       rst;
    logic       dv;
    logic [3:0] din;
    logic       rdy;
    logic       d;
    logic       dval;
    logic       fs;
    logic       busy;
    logic       ds_en;
    logic [3:0] ds;
  } vec_t;

  vec_t vecs [25];

  function automatic vec_t mkv(input logic r, input logic v, input logic [3:0] x,
                               input logic er, input logic ed, input logic ev,
                               input logic ef, input logic eb,
                               input logic se, input logic [3:0] sd);
    vec_t t;
    t.rst = r; t.dv = v; t.din = x; t.rdy = er; t.d = ed; t.dval = ev;
    t.fs = ef; t.busy = eb; t.ds_en = se; t.ds = sd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] x);
    @(negedge clk);
    rst = r; dv = v; din = x;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ed, input logic ev,
                         input logic ef, input logic eb);
    chk({tag, ".d"}, 32'(d), 32'(ed));
    chk({tag, ".d_valid"}, 32'(dval), 32'(ev));
    chk({tag, ".frame_start"}, 32'(fs), 32'(ef));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
  endtask

  logic [3:0] accq [$];
  logic [3:0] outq [$];
  logic [3:0] acc;
  int unsigned nb;
  int unsigned nextv;
  logic        seen_full;
  int unsigned fs_cnt;
  logic [7:0]  w8;
  logic [3:0]  w9;

  initial begin
    //        rst dv din    rdy d dv fs busy ds_en ds
    vecs[0]  = mkv(1, 1, 4'hF, 0, 0, 0, 0, 0, 0, 4'h0);
    vecs[1]  = mkv(1, 1, 4'hF, 0, 0, 0, 0, 0, 0, 4'h0);
    vecs[2]  = mkv(1, 1, 4'hF, 0, 0, 0, 0, 0, 0, 4'h0);
    vecs[3]  = mkv(0, 0, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0);
    vecs[4]  = mkv(0, 1, 4'hB, 1, 0, 0, 0, 0, 0, 4'h0);
    vecs[5]  = mkv(0, 0, 4'h0, 1, 0, 0, 0, 1, 0, 4'h0);
    vecs[6]  = mkv(0, 0, 4'h0, 1, 1, 1, 1, 1, 0, 4'h0);
    vecs[7]  = mkv(0, 0, 4'h0, 1, 0, 1, 0, 1, 0, 4'h0);
    vecs[8]  = mkv(0, 0, 4'h0, 1, 1, 1, 0, 1, 0, 4'h0);
    vecs[9]  = mkv(0, 0, 4'h0, 1, 1, 1, 0, 1, 0, 4'h0);
    vecs[10] = mkv(0, 1, 4'hA, 1, 0, 0, 0, 0, 1, 4'hB);
    vecs[11] = mkv(0, 1, 4'h5, 1, 0, 0, 0, 1, 0, 4'h0);
    vecs[12] = mkv(0, 1, 4'hF, 1, 1, 1, 1, 1, 0, 4'h0);
    vecs[13] = mkv(0, 0, 4'h0, 0, 0, 1, 0, 1, 0, 4'h0);
    vecs[14] = mkv(0, 0, 4'h0, 0, 1, 1, 0, 1, 0, 4'h0);
    vecs[15] = mkv(0, 0, 4'h0, 0, 0, 1, 0, 1, 0, 4'h0);
    vecs[16] = mkv(0, 0, 4'h0, 1, 0, 1, 1, 1, 0, 4'h0);
    vecs[17] = mkv(0, 0, 4'h0, 1, 1, 1, 0, 1, 0, 4'h0);
    vecs[18] = mkv(0, 0, 4'h0, 1, 0, 1, 0, 1, 0, 4'h0);
    vecs[19] = mkv(0, 0, 4'h0, 1, 1, 1, 0, 1, 0, 4'h0);
    vecs[20] = mkv(0, 0, 4'h0, 1, 1, 1, 1, 1, 0, 4'h0);
    vecs[21] = mkv(0, 0, 4'h0, 1, 1, 1, 0, 1, 0, 4'h0);
    vecs[22] = mkv(0, 0, 4'h0, 1, 1, 1, 0, 1, 0, 4'h0);
    vecs[23] = mkv(0, 0, 4'h0, 1, 1, 1, 0, 1, 0, 4'h0);
    vecs[24] = mkv(0, 0, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0);

    rst = 1'b1; dv = 1'b0; din = '0;
    rst8 = 1'b1; dv8 = 1'b0; din8 = '0;
    @(posedge clk);

    // Reset, single word 1011, back-to-back A/5/F
    for (int i = 0; i < 25; i++) begin
      step(vecs[i].rst, vecs[i].dv, vecs[i].din);
      chk($sformatf("vec%0d.din_ready", i), 32'(rdy), 32'(vecs[i].rdy));
      chk_out($sformatf("vec%0d", i), vecs[i].d, vecs[i].dval, vecs[i].fs, vecs[i].busy);
      if (vecs[i].ds_en) chk($sformatf("vec%0d.downstream", i), 32'(ds), 32'(vecs[i].ds));
    end

    // Backpressure: hold valid with incrementing data, scoreboard the stream
    nextv = 0; seen_full = 1'b0; acc = '0; nb = 0;
    for (int c = 0; c < 60; c++) begin
      step(1'b0, (c < 24), nextv[3:0]);
      if (dv && !rdy) seen_full = 1'b1;
      if (dv && rdy) begin
        accq.push_back(din);
        nextv++;
      end
      if (dval) begin
        if (fs) begin
          acc = '0;
          nb  = 0;
        end
        acc = {acc[2:0], d};
        nb++;
        if (nb == 4) outq.push_back(acc);
      end
    end
    chk("bp.ready_dropped", 32'(seen_full), 32'd1);
    chk("bp.accepted_min", 32'(accq.size() >= 5), 32'd1);
    chk("bp.word_count", 32'(outq.size()), 32'(accq.size()));
    for (int i = 0; i < accq.size() && i < outq.size(); i++)
      chk($sformatf("bp.word%0d", i), 32'(outq[i]), 32'(accq[i]));
    chk("bp.drained_busy", 32'(busy), 32'd0);

    // Reset mid-word: C shifting, 3 buffered, rst after two bits
    step(1'b0, 1'b1, 4'hC);
    step(1'b0, 1'b1, 4'h3);
    step(1'b0, 1'b0, 4'h0);
    chk_out("rmw.bit0", 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 4'h0);
    chk_out("rmw.bit1", 1'b1, 1'b1, 1'b0, 1'b1);
    chk("rmw.ready_in_rst", 32'(rdy), 32'd0);
    step(1'b0, 1'b0, 4'h0);
    chk_out("rmw.after_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rmw.ready_after", 32'(rdy), 32'd1);
    step(1'b0, 1'b1, 4'h9);
    step(1'b0, 1'b0, 4'h0);
    w9 = 4'h9;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 4'h0);
      chk_out($sformatf("rmw.nine%0d", i), w9[3-i], 1'b1, (i == 0), 1'b1);
    end
    step(1'b0, 1'b0, 4'h0);
    chk_out("rmw.no_trace", 1'b0, 1'b0, 1'b0, 1'b0);

    // WIDTH=8: 8'h96
    @(negedge clk); rst8 = 1'b0; #1;
    chk("w8.idle_busy", 32'(busy8), 32'd0);
    @(negedge clk); dv8 = 1'b1; din8 = 8'h96; #1;
    chk("w8.ready", 32'(rdy8), 32'd1);
    @(negedge clk); dv8 = 1'b0; din8 = '0; #1;
    chk("w8.queued_busy", 32'(busy8), 32'd1);
    w8 = 8'h96; fs_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      chk($sformatf("w8.bit%0d", i), 32'(d8), 32'(w8[7-i]));
      chk($sformatf("w8.valid%0d", i), 32'(dval8), 32'd1);
      if (fs8) fs_cnt++;
    end
    chk("w8.frame_start_count", fs_cnt, 32'd1);
    @(negedge clk); #1;
    chk("w8.end_valid", 32'(dval8), 32'd0);
    chk("w8.end_busy", 32'(busy8), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
